// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace multiplier: the default operand width,
// the depth of the carry-save tree and the Baugh-Wooley correction constant.
package wallace_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Each 3:2 level turns every full group of three rows into two.
   function automatic int rows_at_level(input int rows, input int level);
      int n;
      n = rows;
      for (int l = 0; l < level; l++) begin
         if (n > 2) n = n - n / 3;
      end
      return n;
   endfunction

   function automatic int reduction_levels(input int rows);
      int n;
      int lv;
      n  = rows;
      lv = 0;
      while (n > 2) begin
         n  = n - n / 3;
         lv = lv + 1;
      end
      return lv;
   endfunction

   function automatic logic [63:0] bw_const(input int width);
      logic [63:0] c;
      c              = '0;
      c[width]       = 1'b1;
      c[2*width-1]   = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/wallace_reducer.sv
// Combinational Wallace tree: applies the Baugh-Wooley term inversions for signed beats,
// adds the correction row and reduces everything to two carry-save rows.
module wallace_reducer
   import wallace_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0][WIDTH-1:0] pp,
   input  logic                        Signed,
   output logic [2*WIDTH-1:0]          row0,
   output logic [2*WIDTH-1:0]          row1
);

   localparam int W2 = 2 * WIDTH;
   localparam int NR = WIDTH + 1;
   localparam int LV = reduction_levels(NR);
   localparam logic [63:0] BW = bw_const(WIDTH);

   logic [W2-1:0] lvl [LV+1][NR];

   for (genvar i = 0; i < WIDTH; i++) begin : g_rows
      logic [WIDTH-1:0] t;
      always_comb begin
         t = pp[i];
         if (Signed) begin
            if (i == WIDTH - 1) t[WIDTH-2:0] = ~pp[i][WIDTH-2:0];
            else                t[WIDTH-1]   = ~pp[i][WIDTH-1];
         end
      end
      assign lvl[0][i] = W2'(t) << i;
   end

   assign lvl[0][WIDTH] = Signed ? BW[W2-1:0] : '0;

   // Row triples become a sum row and a shifted carry row; leftovers pass straight down.
   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int N = rows_at_level(NR, l);
      localparam int T = N / 3;
      for (genvar j = 0; j < NR; j++) begin : g_out
         if (j < 2 * T && j % 2 == 0) begin : g_sum
            assign lvl[l+1][j] = lvl[l][3*(j/2)] ^ lvl[l][3*(j/2)+1] ^ lvl[l][3*(j/2)+2];
         end else if (j < 2 * T) begin : g_carry
            assign lvl[l+1][j] = ((lvl[l][3*(j/2)]   & lvl[l][3*(j/2)+1]) |
                                  (lvl[l][3*(j/2)]   & lvl[l][3*(j/2)+2]) |
                                  (lvl[l][3*(j/2)+1] & lvl[l][3*(j/2)+2])) << 1;
         end else if (j < N - T) begin : g_pass
            assign lvl[l+1][j] = lvl[l][j+T];
         end else begin : g_zero
            assign lvl[l+1][j] = '0;
         end
      end
   end

   assign row0 = lvl[LV][0];
   assign row1 = lvl[LV][1];

endmodule

// File: rtl/wallace_multiplier_pipe.sv
// Three-stage stallable multiplier: operand register, Wallace reduction register and
// final carry-propagate adder register, all advancing together under one handshake.
module wallace_multiplier_pipe
   import wallace_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 Signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   Out
);

   logic                        advance;
   logic                        s1_v;
   logic [WIDTH-1:0]            s1_a;
   logic [WIDTH-1:0]            s1_b;
   logic                        s1_sgn;
   logic [WIDTH-1:0][WIDTH-1:0] pp;
   logic [2*WIDTH-1:0]          red0;
   logic [2*WIDTH-1:0]          red1;
   logic                        s2_v;
   logic [2*WIDTH-1:0]          s2_r0;
   logic [2*WIDTH-1:0]          s2_r1;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !rst;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      assign pp[i] = s1_a & {WIDTH{s1_b[i]}};
   end

   wallace_reducer #(.WIDTH(WIDTH)) u_reducer (
      .pp     (pp),
      .Signed (s1_sgn),
      .row0   (red0),
      .row1   (red1)
   );

   // Data registers only reload behind a valid bit, so bubbles leave the last values in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v      <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_sgn    <= 1'b0;
         s2_v      <= 1'b0;
         s2_r0     <= '0;
         s2_r1     <= '0;
         out_valid <= 1'b0;
         Out       <= '0;
      end else if (advance) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_sgn <= Signed;
         end
         s2_v <= s1_v;
         if (s1_v) begin
            s2_r0 <= red0;
            s2_r1 <= red1;
         end
         out_valid <= s2_v;
         if (s2_v) Out <= s2_r0 + s2_r1;
      end
   end

endmodule
